rob_ctrl: RTL and testbench

Reorder buffer for the Tomasulo core: a circular queue of in-flight instructions between dispatch and the register file. It allocates an entry per dispatched instruction, drives the register file's rename update, and collects results from the common data bus. It retires in program order, driving the register file's write port, and signals branch mispredictions to flush the machine.

---
 rtl/rob_pkg.sv | 13 +
 rtl/rob_ptr.sv | 52 +++++
 rtl/rob_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rob_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: buffer geometry and instruction-type encodings.
package rob_pkg;

   localparam int ROB_SIZE = 16;
   localparam int IDX_W    = $clog2(ROB_SIZE);

   typedef enum logic [1:0] {
      TYPE_ALU = 2'd0,
      TYPE_BR  = 2'd1,
      TYPE_ST  = 2'd2
   } rob_type_e;

endpackage

// File: rtl/rob_ptr.sv
// Head/tail/occupancy pointer unit for the reorder buffer; wraps modulo ROB_SIZE
// and collapses to empty on a flush.
module rob_ptr
   import rob_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [IDX_W-1:0] head_o,
   output logic [IDX_W-1:0] tail_o,
   output logic [IDX_W:0]   count_o
);

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) tail_d = tail_q + IDX_W'(1);
         if (pop_i)  head_d = head_q + IDX_W'(1);
         if (push_i && !pop_i)      count_d = count_q + (IDX_W+1)'(1);
         else if (pop_i && !push_i) count_d = count_q - (IDX_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer controller: in-order retirement, CDB result capture and branch flush.
// Defining ROB_BYPASS_EN adds two combinational operand-query ports with CDB forwarding.
module rob_ctrl
   import rob_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   input  logic [1:0]       alloc_type,
   input  logic             alloc_pred,
   input  logic [31:0]      alloc_pc_alt,
   output logic             full,
   output logic [IDX_W-1:0] alloc_idx,
   output logic             upd,
   output logic [IDX_W-1:0] upd_idx,
   output logic [4:0]       upd_rd,
   input  logic             cdb_valid,
   input  logic [IDX_W-1:0] cdb_idx,
   input  logic [31:0]      cdb_val,
   input  logic             cdb_taken,
   output logic             write,
   output logic [IDX_W-1:0] write_idx,
   output logic [4:0]       write_rd,
   output logic [31:0]      new_val,
   output logic             store_commit,
   output logic             jp_wrong,
   output logic [31:0]      jp_pc
`ifdef ROB_BYPASS_EN
   ,
   input  logic [IDX_W-1:0] q1_idx,
   input  logic [IDX_W-1:0] q2_idx,
   output logic             q1_ready,
   output logic             q2_ready,
   output logic [31:0]      q1_val,
   output logic [31:0]      q2_val
`endif
);

   logic [IDX_W-1:0] head, tail;
   logic [IDX_W:0]   count;
   logic             allocFire, commitFire, cdbHit;

   logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
   logic [ROB_SIZE-1:0] pred_q, taken_q;
   logic [4:0]          rd_q    [ROB_SIZE];
   logic [1:0]          type_q  [ROB_SIZE];
   logic [31:0]         val_q   [ROB_SIZE];
   logic [31:0]         pcAlt_q [ROB_SIZE];

   logic             write_q, write_d, storeCommit_q, storeCommit_d, jpWrong_q, jpWrong_d;
   logic [IDX_W-1:0] writeIdx_q, writeIdx_d;
   logic [4:0]       writeRd_q, writeRd_d;
   logic [31:0]      newVal_q, newVal_d, jpPc_q, jpPc_d;

   assign full       = (count == (IDX_W+1)'(ROB_SIZE));
   assign allocFire  = alloc_valid && !full && !jpWrong_q && rdy;
   assign commitFire = busy_q[head] && ready_q[head] && rdy && !jpWrong_q;
   assign cdbHit     = cdb_valid && busy_q[cdb_idx] && rdy;

   assign alloc_idx = tail;
   assign upd       = allocFire;
   assign upd_idx   = tail;
   assign upd_rd    = alloc_rd;

   rob_ptr u_ptr (
      .clk     (clk),
      .rst     (rst),
      .push_i  (allocFire),
      .pop_i   (commitFire),
      .flush_i (jpWrong_q),
      .head_o  (head),
      .tail_o  (tail),
      .count_o (count)
   );

   // Commit reads registered ready, so a result landing on the head retires one cycle later.
   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      if (cdbHit) ready_d[cdb_idx] = 1'b1;
      if (commitFire) begin
         busy_d[head]  = 1'b0;
         ready_d[head] = 1'b0;
      end
      if (allocFire) begin
         busy_d[tail]  = 1'b1;
         ready_d[tail] = (alloc_type == TYPE_ST);
      end
      if (jpWrong_q) begin
         busy_d  = '0;
         ready_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         ready_q <= '0;
      end else begin
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (allocFire) begin
         rd_q[tail]    <= alloc_rd;
         type_q[tail]  <= alloc_type;
         pred_q[tail]  <= alloc_pred;
         pcAlt_q[tail] <= alloc_pc_alt;
      end
      if (cdbHit) begin
         val_q[cdb_idx]   <= cdb_val;
         taken_q[cdb_idx] <= cdb_taken;
      end
   end

   always_comb begin
      write_d       = 1'b0;
      storeCommit_d = 1'b0;
      jpWrong_d     = 1'b0;
      writeIdx_d    = writeIdx_q;
      writeRd_d     = writeRd_q;
      newVal_d      = newVal_q;
      jpPc_d        = jpPc_q;
      if (commitFire) begin
         case (type_q[head])
            TYPE_ST: storeCommit_d = 1'b1;
            TYPE_BR: begin
               if (taken_q[head] != pred_q[head]) begin
                  jpWrong_d = 1'b1;
                  jpPc_d    = pcAlt_q[head];
               end
            end
            default: begin
               write_d    = 1'b1;
               writeIdx_d = head;
               writeRd_d  = rd_q[head];
               newVal_d   = val_q[head];
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_q       <= 1'b0;
         storeCommit_q <= 1'b0;
         jpWrong_q     <= 1'b0;
         writeIdx_q    <= '0;
         writeRd_q     <= '0;
         newVal_q      <= '0;
         jpPc_q        <= '0;
      end else begin
         write_q       <= write_d;
         storeCommit_q <= storeCommit_d;
         jpWrong_q     <= jpWrong_d;
         writeIdx_q    <= writeIdx_d;
         writeRd_q     <= writeRd_d;
         newVal_q      <= newVal_d;
         jpPc_q        <= jpPc_d;
      end
   end

   assign write        = write_q;
   assign write_idx    = writeIdx_q;
   assign write_rd     = writeRd_q;
   assign new_val      = newVal_q;
   assign store_commit = storeCommit_q;
   assign jp_wrong     = jpWrong_q;
   assign jp_pc        = jpPc_q;

`ifdef ROB_BYPASS_EN
   // A same-cycle CDB broadcast to a live entry is forwarded ahead of the latch.
   assign q1_ready = busy_q[q1_idx] && (ready_q[q1_idx] || (cdb_valid && cdb_idx == q1_idx));
   assign q2_ready = busy_q[q2_idx] && (ready_q[q2_idx] || (cdb_valid && cdb_idx == q2_idx));
   assign q1_val   = (cdb_valid && cdb_idx == q1_idx) ? cdb_val : val_q[q1_idx];
   assign q2_val   = (cdb_valid && cdb_idx == q2_idx) ? cdb_val : val_q[q2_idx];
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios plus random traffic against a
// queue-based model of the in-flight instruction window.
module tb_rob_ctrl;
   import rob_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, alloc_valid, alloc_pred, cdb_valid, cdb_taken;
   logic [4:0]  alloc_rd;
   logic [1:0]  alloc_type;
   logic [31:0] alloc_pc_alt, cdb_val;
   logic [3:0]  cdb_idx, q1_idx, q2_idx;
   logic        full, upd, write, store_commit, jp_wrong;
   logic [3:0]  alloc_idx, upd_idx, write_idx;
   logic [4:0]  upd_rd, write_rd;
   logic [31:0] new_val, jp_pc;
`ifdef ROB_BYPASS_EN
   logic        q1_ready, q2_ready;
   logic [31:0] q1_val, q2_val;
`endif

   always #5 clk = ~clk;

   rob_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_type(alloc_type),
      .alloc_pred(alloc_pred), .alloc_pc_alt(alloc_pc_alt),
      .full(full), .alloc_idx(alloc_idx), .upd(upd), .upd_idx(upd_idx), .upd_rd(upd_rd),
      .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
      .write(write), .write_idx(write_idx), .write_rd(write_rd), .new_val(new_val),
      .store_commit(store_commit), .jp_wrong(jp_wrong), .jp_pc(jp_pc)
`ifdef ROB_BYPASS_EN
      , .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_val(q1_val), .q2_val(q2_val)
`endif
   );

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic [1:0]  typ;
      logic        pred;
      logic [31:0] pcAlt;
      logic        rdyBit;
      logic        valKnown;
      logic [31:0] val;
      logic        taken;
   } entry_t;

   entry_t      mq[$];
   int          tailPtr;
   logic        expWrite, expStore, expJp;
   logic [3:0]  expWriteIdx;
   logic [4:0]  expWriteRd;
   logic [31:0] expNewVal, expJpPc;
   int          checks = 0;
   int          errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int findTag(input int t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   function automatic void modelReset();
      mq.delete();
      tailPtr     = 0;
      expWrite    = 1'b0;
      expStore    = 1'b0;
      expJp       = 1'b0;
      expWriteIdx = '0;
      expWriteRd  = '0;
      expNewVal   = '0;
      expJpPc     = '0;
   endfunction

`ifdef ROB_BYPASS_EN
   task automatic checkQuery(input string tag, input logic [3:0] qi, input logic qr,
                             input logic [31:0] qv, input logic cv, input logic [3:0] ci,
                             input logic [31:0] cval);
      int   k;
      logic hit, expR;
      k    = findTag(int'(qi));
      hit  = cv && (ci == qi);
      expR = (k >= 0) && (mq[k].rdyBit || hit);
      checkOutput({tag, "_ready"}, 32'(qr), 32'(expR));
      if (expR && (hit || mq[k].valKnown))
         checkOutput({tag, "_val"}, qv, hit ? cval : mq[k].val);
   endtask
`endif

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_type = '0;
      alloc_pred = 1'b0; alloc_pc_alt = '0; cdb_valid = 1'b0; cdb_idx = '0;
      cdb_val = '0; cdb_taken = 1'b0; q1_idx = '0; q2_idx = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("rst_write", 32'(write), 32'd0);
      checkOutput("rst_store_commit", 32'(store_commit), 32'd0);
      checkOutput("rst_jp_wrong", 32'(jp_wrong), 32'd0);
      checkOutput("rst_jp_pc", jp_pc, 32'd0);
      checkOutput("rst_new_val", new_val, 32'd0);
      checkOutput("rst_write_idx", 32'(write_idx), 32'd0);
      checkOutput("rst_write_rd", 32'(write_rd), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_alloc_idx", 32'(alloc_idx), 32'd0);
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input logic r, input logic av, input logic [4:0] ard,
                                input logic [1:0] at, input logic ap, input logic [31:0] apc,
                                input logic cv, input logic [3:0] ci, input logic [31:0] cval,
                                input logic ct, input logic [3:0] q1, input logic [3:0] q2);
      logic   allocOk, commitOk, oldJp;
      entry_t e;
      int     k;
      @(negedge clk);
      rdy = r; alloc_valid = av; alloc_rd = ard; alloc_type = at; alloc_pred = ap;
      alloc_pc_alt = apc; cdb_valid = cv; cdb_idx = ci; cdb_val = cval; cdb_taken = ct;
      q1_idx = q1; q2_idx = q2;
      #1;
      oldJp    = expJp;
      allocOk  = av && (mq.size() < ROB_SIZE) && !oldJp && r;
      commitOk = (mq.size() > 0) && mq[0].rdyBit && r && !oldJp;
      checkOutput("full", 32'(full), 32'(mq.size() == ROB_SIZE));
      checkOutput("alloc_idx", 32'(alloc_idx), 32'(tailPtr));
      checkOutput("upd", 32'(upd), 32'(allocOk));
      if (allocOk) begin
         checkOutput("upd_idx", 32'(upd_idx), 32'(tailPtr));
         checkOutput("upd_rd", 32'(upd_rd), 32'(ard));
      end
`ifdef ROB_BYPASS_EN
      checkQuery("q1", q1, q1_ready, q1_val, cv, ci, cval);
      checkQuery("q2", q2, q2_ready, q2_val, cv, ci, cval);
`endif
      expWrite = 1'b0;
      expStore = 1'b0;
      expJp    = 1'b0;
      if (oldJp) begin
         mq.delete();
         tailPtr = 0;
      end else begin
         if (commitOk) begin
            e = mq.pop_front();
            case (e.typ)
               2'd2: expStore = 1'b1;
               2'd1: if (e.taken != e.pred) begin expJp = 1'b1; expJpPc = e.pcAlt; end
               default: begin
                  expWrite    = 1'b1;
                  expWriteIdx = 4'(e.tag);
                  expWriteRd  = e.rd;
                  expNewVal   = e.val;
               end
            endcase
         end
         if (cv && r) begin
            k = findTag(int'(ci));
            if (k >= 0) begin
               mq[k].rdyBit   = 1'b1;
               mq[k].valKnown = 1'b1;
               mq[k].val      = cval;
               mq[k].taken    = ct;
            end
         end
         if (allocOk) begin
            e.tag = tailPtr; e.rd = ard; e.typ = at; e.pred = ap; e.pcAlt = apc;
            e.rdyBit = (at == 2'd2); e.valKnown = 1'b0; e.val = '0; e.taken = 1'b0;
            mq.push_back(e);
            tailPtr = (tailPtr + 1) % ROB_SIZE;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("write", 32'(write), 32'(expWrite));
      if (expWrite) begin
         checkOutput("write_idx", 32'(write_idx), 32'(expWriteIdx));
         checkOutput("write_rd", 32'(write_rd), 32'(expWriteRd));
         checkOutput("new_val", new_val, expNewVal);
      end
      checkOutput("store_commit", 32'(store_commit), 32'(expStore));
      checkOutput("jp_wrong", 32'(jp_wrong), 32'(expJp));
      if (expJp) checkOutput("jp_pc", jp_pc, expJpPc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   logic [3:0] rCi;
   logic [1:0] rType;

   initial begin
      $display("[TB] start");
      applyReset();

      // Fill all 16 entries, then a 17th request must be refused with tail back at 0.
      for (int i = 0; i < 17; i++)
         applyStimulus(1, 1, 5'(i + 1), 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyReset();

      // Single ALU result retires two edges after its CDB broadcast.
      applyStimulus(1, 1, 5'd5, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd0, 32'h1234, 0, 0, 0);
      idle(3);

      // Mispredicted branch flushes; the allocation during the pulse cycle is ignored.
      applyReset();
      applyStimulus(1, 1, 5'd0, 2'd1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5'd7, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd0, 32'h0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5'd9, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // Out-of-order completion 2,0,1 retires in order 0,1,2.
      applyReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 1, 5'(10 + i), 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd2, 32'hC2, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd0, 32'hC0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd1, 32'hC1, 0, 0, 0);
      idle(4);

      // Full buffer drained one per cycle with alloc_valid held high; tail wraps.
      applyReset();
      for (int i = 0; i < 16; i++)
         applyStimulus(1, 1, 5'(i), 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 24; i++)
         applyStimulus(1, 1, 5'(i), 2'd2, 0, 0, 1, 4'(i), 32'(i * 3 + 1), 0, 0, 0);
      idle(18);

`ifdef ROB_BYPASS_EN
      applyReset();
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 1, 5'(i + 1), 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 4'd3, 32'hAB, 0, 4'd3, 4'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd0);
`endif

      // Random traffic, including stalls, stores, branches and periodic resets.
      applyReset();
      for (int n = 0; n < 3000; n++) begin
         if (n % 900 == 899) applyReset();
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            rCi = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
         else
            rCi = 4'($urandom_range(0, 15));
         rType = 2'($urandom_range(0, 2));
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                       5'($urandom), rType, 1'($urandom), $urandom,
                       $urandom_range(0, 1) == 1, rCi, $urandom, 1'($urandom),
                       4'($urandom), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
